// File: rtl/conv_decoder_bs.sv
// rtl/conv_decoder_bs.sv - hard-decision Viterbi decoder, rate-1/3 K=7 tail-biting (133/171/165)
module conv_decoder_bs #(
   parameter int SMALL_LEN = 1056,
   parameter int LARGE_LEN = 6144,
   parameter int MW        = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       code_block_length,
   input  logic       sub_empty,
   input  logic [7:0] q0,
   input  logic [7:0] q1,
   input  logic [7:0] q2,
   output logic       rdreq_subblock,
   input  logic       dec_full,
   output logic [7:0] dec_data,
   output logic       dec_wrreq,
   output logic       length_out,
   output logic       decode_done,
   output logic       busy
);
   localparam int AW = $clog2(LARGE_LEN + 1);
   localparam int BW = AW - 3;

   typedef enum logic [3:0] {IDLE, LOAD, POP, CAPT, ACS, SELECT, TRACE, OUTPUT, DONE} state_t;
   state_t state;

   logic [MW-1:0] pm    [64];
   logic [MW-1:0] pm_nx [64];
   logic [63:0]   dvec;
   logic [7:0]    b0, b1, b2;
   logic [2:0]    bit_cnt, rx;
   logic [AW-1:0] step, n_len, rd_addr;
   logic [5:0]    sel_i, tstate;
   logic [MW-1:0] best, diff_sel;
   logic [BW-1:0] oidx, ob_raddr;
   logic          ovld, fire;
   logic [63:0]   surv [LARGE_LEN];
   logic [63:0]   rd_data;
   logic [7:0]    obuf [1 << BW];

   // Branch metric for predecessor p={c1..c6} taking input u.
   function automatic logic [MW-1:0] bm(input logic [5:0] p, input logic u, input logic [2:0] r);
      logic e0, e1, e2;
      e0 = u ^ p[4] ^ p[3] ^ p[1] ^ p[0];
      e1 = u ^ p[5] ^ p[4] ^ p[3] ^ p[0];
      e2 = u ^ p[5] ^ p[4] ^ p[2] ^ p[0];
      return MW'(e0 ^ r[2]) + MW'(e1 ^ r[1]) + MW'(e2 ^ r[0]);
   endfunction

   always_comb begin
      logic [MW-1:0] c0, c1, cd;
      c0 = '0;
      c1 = '0;
      cd = '0;
      dvec = '0;
      rx = {b0[3'd7 - bit_cnt], b1[3'd7 - bit_cnt], b2[3'd7 - bit_cnt]};
      for (int ns = 0; ns < 64; ns++) begin
         c0 = pm[{ns[4:0], 1'b0}] + bm({ns[4:0], 1'b0}, ns[5], rx);
         c1 = pm[{ns[4:0], 1'b1}] + bm({ns[4:0], 1'b1}, ns[5], rx);
         cd = c1 - c0;
         dvec[ns]  = cd[MW-1];
         pm_nx[ns] = cd[MW-1] ? c1 : c0;
      end
   end

   assign diff_sel  = pm[sel_i] - best;
   assign fire      = (state == OUTPUT) && ovld && !dec_full;
   assign dec_wrreq = fire;
   assign ob_raddr  = fire ? oidx + BW'(1) : oidx;
   assign rd_addr   = (step == '0) ? '0 : step - AW'(1);

   // Survivor and output-bit storage carry no reset; the FSM never reads stale entries.
   always_ff @(posedge clk) begin
      if (state == ACS)
         surv[step] <= dvec;
      if (state == TRACE)
         obuf[step[AW-1:3]][3'd7 - step[2:0]] <= tstate[5];
      rd_data <= surv[rd_addr];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         pm             <= '{default: '0};
         b0             <= '0;
         b1             <= '0;
         b2             <= '0;
         bit_cnt        <= '0;
         step           <= '0;
         n_len          <= '0;
         sel_i          <= '0;
         tstate         <= '0;
         best           <= '0;
         oidx           <= '0;
         ovld           <= 1'b0;
         rdreq_subblock <= 1'b0;
         dec_data       <= '0;
         length_out     <= 1'b0;
         decode_done    <= 1'b0;
         busy           <= 1'b0;
      end else begin
         rdreq_subblock <= 1'b0;
         decode_done    <= 1'b0;
         case (state)
            IDLE: if (start) begin
               length_out <= code_block_length;
               n_len      <= code_block_length ? AW'(LARGE_LEN) : AW'(SMALL_LEN);
               step       <= '0;
               pm         <= '{default: '0};
               busy       <= 1'b1;
               state      <= LOAD;
            end
            LOAD: if (!sub_empty) begin
               rdreq_subblock <= 1'b1;
               state          <= POP;
            end
            POP:  state <= CAPT;
            CAPT: begin
               b0      <= q0;
               b1      <= q1;
               b2      <= q2;
               bit_cnt <= '0;
               state   <= ACS;
            end
            ACS: begin
               pm      <= pm_nx;
               step    <= step + AW'(1);
               bit_cnt <= bit_cnt + 3'd1;
               sel_i   <= '0;
               if (bit_cnt == 3'd7)
                  state <= (step + AW'(1) == n_len) ? SELECT : LOAD;
            end
            SELECT: begin
               if (sel_i == 6'd0 || diff_sel[MW-1]) begin
                  best   <= pm[sel_i];
                  tstate <= sel_i;
               end
               sel_i <= sel_i + 6'd1;
               if (sel_i == 6'd63) begin
                  step  <= step - AW'(1);
                  state <= TRACE;
               end
            end
            TRACE: begin
               tstate <= {tstate[4:0], rd_data[tstate]};
               if (step == '0) begin
                  oidx  <= '0;
                  ovld  <= 1'b0;
                  state <= OUTPUT;
               end else begin
                  step <= step - AW'(1);
               end
            end
            OUTPUT: begin
               // First cycle only primes the byte read; writes start once ovld is set.
               ovld     <= 1'b1;
               dec_data <= obuf[ob_raddr];
               if (fire) begin
                  oidx <= oidx + BW'(1);
                  if (oidx == n_len[AW-1:3] - BW'(1)) begin
                     decode_done <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_decoder_bs.sv
// tb/tb_conv_decoder_bs.sv - randomized bench for conv_decoder_bs against a behavioural Viterbi model
module tb_conv_decoder_bs;
   localparam int SMALL = 1056;
   localparam int LARGE = 6144;

   logic       clk = 1'b0;
   logic       reset, start, code_block_length, sub_empty, dec_full;
   logic [7:0] q0, q1, q2, dec_data;
   logic       rdreq_subblock, dec_wrreq, length_out, decode_done, busy;

   conv_decoder_bs dut (
      .clk(clk), .reset(reset), .start(start), .code_block_length(code_block_length),
      .sub_empty(sub_empty), .q0(q0), .q1(q1), .q2(q2), .rdreq_subblock(rdreq_subblock),
      .dec_full(dec_full), .dec_data(dec_data), .dec_wrreq(dec_wrreq),
      .length_out(length_out), .decode_done(decode_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int gen [3] = '{7'o133, 7'o171, 7'o165};
   int n;
   bit msg [LARGE];
   bit dbit [LARGE];
   bit rxb [3][LARGE];
   bit dm [LARGE][64];
   logic [7:0] cbyte [3][LARGE/8];
   logic [7:0] dbytes [LARGE/8];

   int passed, total;
   int cyc, pops, wr_count, done_count, full_left;
   bit stall_mode, full_arm;
   logic exp_len;
   logic [23:0] fifo_q [$];
   logic [7:0]  exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   function automatic bit par(input int v);
      return ^v;
   endfunction

   // Tail-biting encoder: the register starts with the last six message bits.
   task automatic encode();
      for (int k = 0; k < n; k++) begin
         int w;
         w = 0;
         for (int j = 0; j <= 6; j++)
            w |= int'(msg[(k - j + n) % n]) << (6 - j);
         for (int g = 0; g < 3; g++)
            rxb[g][k] = par(w & gen[g]);
      end
   endtask

   task automatic model_decode();
      int pm [64];
      int npm [64];
      int c [2];
      int p, w, bmv, bst, t;
      for (int s = 0; s < 64; s++) pm[s] = 0;
      for (int k = 0; k < n; k++) begin
         for (int ns = 0; ns < 64; ns++) begin
            for (int b = 0; b < 2; b++) begin
               p = ((ns & 31) << 1) | b;
               w = (ns << 1) | b;
               bmv = 0;
               for (int g = 0; g < 3; g++)
                  if (par(w & gen[g]) != rxb[g][k]) bmv++;
               c[b] = pm[p] + bmv;
            end
            dm[k][ns] = (c[1] < c[0]);
            npm[ns]   = (c[1] < c[0]) ? c[1] : c[0];
         end
         pm = npm;
      end
      bst = 0;
      for (int s = 1; s < 64; s++)
         if (pm[s] < pm[bst]) bst = s;
      t = bst;
      for (int k = n - 1; k >= 0; k--) begin
         dbit[k] = bit'((t >> 5) & 1);
         t = ((t & 31) << 1) | int'(dm[k][t]);
      end
      for (int k = 0; k < n; k++)
         dbytes[k / 8][7 - (k % 8)] = dbit[k];
   endtask

   // kind: 0 zeros, 1 random, 2 random with isolated coded-bit errors, 3 all ones, 4 single impulse
   task automatic prep(input bit len, input int kind);
      int e;
      n = len ? LARGE : SMALL;
      for (int k = 0; k < n; k++)
         case (kind)
            0:       msg[k] = 1'b0;
            3:       msg[k] = 1'b1;
            4:       msg[k] = (k == 0);
            default: msg[k] = bit'($urandom_range(0, 1));
         endcase
      encode();
      if (kind == 2)
         for (int p = 60; p + 10 < 3 * n - 60; p += 40) begin
            e = p + int'($urandom_range(0, 9));
            rxb[e % 3][e / 3] ^= 1'b1;
         end
      for (int g = 0; g < 3; g++)
         for (int k = 0; k < n; k++)
            cbyte[g][k / 8][7 - (k % 8)] = rxb[g][k];
      model_decode();
   endtask

   function automatic int model_errors();
      int m;
      m = 0;
      for (int k = 0; k < n; k++)
         if (dbit[k] != msg[k]) m++;
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic launch(input bit len);
      fifo_q.delete();
      exp_q.delete();
      for (int b = 0; b < n / 8; b++) begin
         fifo_q.push_back({cbyte[0][b], cbyte[1][b], cbyte[2][b]});
         exp_q.push_back(dbytes[b]);
      end
      pops = 0;
      wr_count = 0;
      done_count = 0;
      exp_len = len;
      code_block_length = len;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic finish_block(input string tag);
      int i;
      i = 0;
      while (done_count == 0 && i < 40000) begin
         tick();
         i++;
      end
      repeat (4) tick();
      check({tag, "_done_once"}, done_count, 1);
      check({tag, "_pops"}, pops, n / 8);
      check({tag, "_bytes"}, wr_count, n / 8);
      check({tag, "_idle"}, busy, 1'b0);
   endtask

   // Single compare process: FIFO model for the subblock side, scoreboard for the byte side.
   always @(negedge clk) begin
      if (reset) begin
         if (dec_full) check("wrreq_while_full", dec_wrreq, 1'b0);
         if (dec_wrreq) begin
            wr_count++;
            check("byte_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("dec_data", dec_data, exp_q.pop_front());
         end
         if (rdreq_subblock) begin
            check("pop_has_data", fifo_q.size() != 0, 1'b1);
            if (fifo_q.size() != 0) {q0, q1, q2} = fifo_q.pop_front();
            pops++;
         end
         if (decode_done) begin
            done_count++;
            check("done_all_bytes", exp_q.size(), 0);
            check("length_out", length_out, exp_len);
         end
         cyc++;
         sub_empty = (fifo_q.size() == 0) || (stall_mode && ((cyc / 3) % 2 == 1));
         if (full_arm && wr_count == 40) begin
            full_left = 50;
            full_arm  = 1'b0;
         end
         dec_full = (full_left > 0);
         if (full_left > 0) full_left--;
      end
   end

   initial begin
      int i;
      reset = 1'b0; start = 1'b0; code_block_length = 1'b0;
      sub_empty = 1'b1; dec_full = 1'b0; q0 = '0; q1 = '0; q2 = '0;
      repeat (3) tick();
      check("reset_outputs", {rdreq_subblock, dec_wrreq, decode_done, busy, length_out, dec_data}, 0);
      reset = 1'b1;
      tick();

      prep(0, 4);
      check("pin_impulse_d0", cbyte[0][0], 8'hB6);
      check("pin_impulse_d1", cbyte[1][0], 8'hF2);
      check("pin_impulse_d2", cbyte[2][0], 8'hEA);
      check("pin_impulse_dec", dbytes[0], 8'h80);
      prep(0, 3);
      check("pin_ones_code", cbyte[1][5], 8'hFF);
      check("pin_ones_dec", dbytes[7], 8'hFF);

      prep(0, 0);
      check("pin_zero_code", cbyte[2][131], 8'h00);
      check("pin_zero_dec", model_errors(), 0);
      launch(0);
      finish_block("zero");

      prep(0, 1);
      check("pin_clean_model", model_errors(), 0);
      launch(0);
      repeat (50) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      finish_block("random");

      prep(0, 2);
      check("pin_noisy_model", model_errors(), 0);
      launch(0);
      finish_block("noisy");

      prep(1, 1);
      stall_mode = 1'b1;
      launch(1);
      finish_block("large_stall");
      stall_mode = 1'b0;

      prep(0, 1);
      full_arm = 1'b1;
      launch(0);
      finish_block("full_hold");

      prep(0, 1);
      launch(0);
      i = 0;
      while (pops < n / 8 && i < 5000) begin
         tick();
         i++;
      end
      repeat (10 + 64 + 300) tick();
      check("trace_busy", busy, 1'b1);
      check("trace_no_output", wr_count, 0);
      reset = 1'b0;
      #1;
      check("abort_outputs", {rdreq_subblock, dec_wrreq, decode_done, busy, dec_data}, 0);
      fifo_q.delete();
      exp_q.delete();
      repeat (3) tick();
      reset = 1'b1;
      tick();
      prep(0, 2);
      launch(0);
      finish_block("after_abort");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
